// File: rtl/sum_uart_pkg.sv
// Shared types and constants for the adder-result UART transmitter.
package sum_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FRAME_BITS = 10;
  localparam logic        UART_IDLE  = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrapping pointers and a separate occupancy counter.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop never frees space for a push in the same cycle: full blocks the push.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/sum_uart_tx.sv
// Buffers adder result bytes and serialises them as contiguous 8N1 UART frames.
module sum_uart_tx
  import sum_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_W - 1);

  state_e              state_q;
  logic [BW-1:0]       baud_q;
  logic [2:0]          bit_q;
  logic [DATA_W-1:0]   shift_q;
  logic                tx_q;
  logic                ready_en_q;

  logic                baud_tc;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DATA_W-1:0]   fifo_head;

  // ready_en_q keeps in_ready low through reset and rises on the first edge after it.
  assign in_ready   = ready_en_q && !fifo_full;
  assign fifo_push  = in_valid && in_ready;
  assign baud_tc    = (baud_q == BAUD_LAST);
  assign fifo_pop   = !fifo_empty &&
                      ((state_q == IDLE) || ((state_q == STOP) && baud_tc));
  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (in_data),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= UART_IDLE;
    end else begin
      baud_q <= baud_tc ? '0 : baud_q + BW'(1);
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          tx_q   <= UART_IDLE;
          if (fifo_pop) begin
            shift_q <= fifo_head;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_tc) begin
            state_q <= DATA;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (baud_tc) begin
            if (bit_q == LAST_BIT) begin
              state_q <= STOP;
              tx_q    <= UART_IDLE;
            end else begin
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
              bit_q   <= bit_q + 3'd1;
            end
          end
        end
        STOP: begin
          // Reloading straight into START keeps back-to-back frames gapless.
          if (baud_tc) begin
            if (fifo_pop) begin
              shift_q <= fifo_head;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_uart_tx.sv
// Self-checking bench for sum_uart_tx: frame-level reference model plus directed sequences.
module tb_sum_uart_tx;
  import sum_uart_pkg::*;

  localparam int unsigned CPB       = 4;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned FRAME_CYC = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_level;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  sum_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted bytes and the time into the current frame.
  byte unsigned mq[$];
  logic [7:0]   m_byte = '0;
  int unsigned  m_t = 0;
  bit           m_act = 1'b0;
  bit           m_done = 1'b0;

  function automatic logic frame_bit(input logic [7:0] b, input int unsigned t);
    int unsigned idx;
    idx = t / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  task automatic model_step();
    bit can_push;
    bit frame_end;
    can_push  = in_valid && m_done && (mq.size() != int'(DEPTH));
    frame_end = !m_act || (m_t == FRAME_CYC - 1);
    if (!frame_end) begin
      m_t++;
    end else if (mq.size() != 0) begin
      m_byte = mq.pop_front();
      m_act  = 1'b1;
      m_t    = 0;
    end else begin
      m_act = 1'b0;
      m_t   = 0;
    end
    if (can_push) mq.push_back(in_data);
    m_done = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_act  = 1'b0;
      m_t    = 0;
      m_done = 1'b0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    chk("model_tx", int'(tx), int'(m_act ? frame_bit(m_byte, m_t) : 1'b1));
    chk("model_busy", int'(busy), int'(m_act));
    chk("model_level", int'(fifo_level), mq.size());
    chk("model_in_ready", int'(in_ready), int'(m_done && (mq.size() != int'(DEPTH))));
  end

  typedef struct {
    int unsigned edge_n;
    logic        tx;
    logic        busy;
    int          level;
  } vec_t;

  vec_t vec[$];

  task automatic wait_drain();
    int unsigned n;
    n = 0;
    while ((busy || fifo_level != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", int'(busy || fifo_level != 0), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_pulse(input int unsigned hold);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_level", int'(fifo_level), 0);
    repeat (hold) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("rel_in_ready_low", int'(in_ready), 0);
    @(negedge clk);
    chk("rel_in_ready_high", int'(in_ready), 1);
    chk("rel_level", int'(fifo_level), 0);
    chk("rel_busy", int'(busy), 0);
  endtask

  initial begin
    logic [7:0] b;
    int unsigned e;
    int unsigned acc;
    bit busy_all;
    int unsigned thresh;

    // Power-on reset
    repeat (3) @(negedge clk);
    chk("por_tx", int'(tx), 1);
    chk("por_in_ready", int'(in_ready), 0);
    #2 rst_n = 1'b1;
    #1 chk("por_rel_in_ready_low", int'(in_ready), 0);
    @(negedge clk);
    chk("por_rel_in_ready_high", int'(in_ready), 1);

    // Single byte 0xA5: table of expected outputs after each listed edge
    b = 8'hA5;
    vec.push_back('{1, 1'b1, 1'b0, 1});
    vec.push_back('{2, 1'b0, 1'b1, 0});
    vec.push_back('{5, 1'b0, 1'b1, 0});
    for (int i = 0; i < 8; i++) begin
      vec.push_back('{6 + 4*i, b[i], 1'b1, 0});
      vec.push_back('{9 + 4*i, b[i], 1'b1, 0});
    end
    vec.push_back('{38, 1'b1, 1'b1, 0});
    vec.push_back('{41, 1'b1, 1'b1, 0});
    vec.push_back('{42, 1'b1, 1'b0, 0});
    in_valid = 1'b1;
    in_data  = b;
    e = 0;
    for (int k = 0; k < vec.size(); k++) begin
      while (e < vec[k].edge_n) begin
        @(negedge clk);
        e++;
        in_valid = 1'b0;
      end
      chk($sformatf("vec%0d_tx", k), int'(tx), int'(vec[k].tx));
      chk($sformatf("vec%0d_busy", k), int'(busy), int'(vec[k].busy));
      chk($sformatf("vec%0d_level", k), int'(fifo_level), vec[k].level);
    end
    wait_drain();

    // Back-to-back frames
    in_valid = 1'b1; in_data = 8'h00;
    @(negedge clk); chk("b2b_level1", int'(fifo_level), 1); in_data = 8'hFF;
    @(negedge clk); chk("b2b_level2", int'(fifo_level), 1); in_data = 8'h3C;
    @(negedge clk); chk("b2b_level3", int'(fifo_level), 2); in_valid = 1'b0;
    busy_all = 1'b1;
    for (int unsigned ed = 4; ed <= 121; ed++) begin
      @(negedge clk);
      busy_all &= busy;
      if (ed == 41 || ed == 81) chk($sformatf("b2b_stop_e%0d", ed), int'(tx), 1);
      if (ed == 42 || ed == 82) chk($sformatf("b2b_start_e%0d", ed), int'(tx), 0);
    end
    chk("b2b_no_gap", int'(busy_all), 1);
    @(negedge clk);
    chk("b2b_busy_end", int'(busy), 0);
    wait_drain();

    // Full FIFO
    in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'h10 + 8'(i);
      if (in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("full_accepted", int'(acc), 5);
    chk("full_level", int'(fifo_level), 4);
    chk("full_in_ready", int'(in_ready), 0);
    wait_drain();

    // Push coinciding with the end-of-stop pop
    in_valid = 1'b1; in_data = 8'h55;
    @(negedge clk); in_data = 8'hAA;
    @(negedge clk); in_data = 8'h0F;
    @(negedge clk); in_valid = 1'b0;
    repeat (38) @(negedge clk);
    chk("pp_level_before", int'(fifo_level), 2);
    chk("pp_stop", int'(tx), 1);
    in_valid = 1'b1; in_data = 8'hC3;
    @(negedge clk); in_valid = 1'b0;
    chk("pp_level_after", int'(fifo_level), 2);
    chk("pp_start", int'(tx), 0);
    chk("pp_busy", int'(busy), 1);
    wait_drain();

    // Reset mid-stream with bytes buffered
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h60 + 8'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset_pulse(5);
    repeat (50) @(negedge clk);
    chk("rst1_quiet_busy", int'(busy), 0);

    // Reset during data bit 3 of 0x81
    in_valid = 1'b1; in_data = 8'h81;
    @(negedge clk); in_valid = 1'b0;
    repeat (18) @(negedge clk);
    chk("rst6_bit3_low", int'(tx), 0);
    reset_pulse(5);
    repeat (50) @(negedge clk);
    chk("rst6_quiet_tx", int'(tx), 1);
    chk("rst6_quiet_level", int'(fifo_level), 0);

    // Randomised traffic with varying offered load
    for (int blk = 0; blk < 15; blk++) begin
      thresh = (blk % 3 == 0) ? 5 : ((blk % 3 == 1) ? 30 : 90);
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        in_valid = ($urandom_range(0, 99) < thresh);
        in_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_uart_tx.md
Name: sum_uart_tx

Overview:
Downstream stage for the 8-bit adder result driven onto uo_out. It accepts 8-bit result bytes over a valid/ready handshake, buffers them in a small FIFO and serialises each byte as a standard 8N1 UART frame on one output pin. This lets the chip stream sums to a host through a single pin.

Parameters:
CLKS_PER_BIT, 87, clock cycles per UART bit (10 MHz / 115200 baud); legal range >= 2.
FIFO_DEPTH, 4, number of buffered bytes; must be a power of two, >= 2.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
in_data  input  8  result byte to transmit
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  FIFO can accept a byte (not full)
tx  output  1  UART serial line, idle high
busy  output  1  a frame is in progress (state != IDLE)
fifo_level  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. While rst_n=0: tx=1, busy=0, in_ready=0, fifo_level=0. FIFO pointers, FSM, bit counter and baud counter are all cleared. in_ready rises on the first clock edge after reset is released.
- Handshake: a push happens on a rising edge where in_valid && in_ready. in_ready = (fifo_level != FIFO_DEPTH), registered-level based. There is no pass-through when full. in_data is sampled only on a push.
- Simultaneous push and pop: both occur in the same cycle and fifo_level is unchanged. If the FIFO is full, no push is possible that cycle even if a pop happens.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: tx=1. If fifo_level != 0, pop the head into the shift register, clear the baud counter and go to START. tx falls on the same edge as the pop.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then the register shifts right. After bit index 7 completes, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. At the end of the stop bit, if the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- Latency: a push into an empty FIFO while IDLE gives the start bit beginning 2 edges later (edge 1 pushes, edge 2 pops).
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. The bit advances on terminal count.
- FIFO wrap: read and write pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Level is tracked by a separate counter.
- Reset mid-frame: tx returns high asynchronously, the partial frame is abandoned and buffered bytes are discarded.
- All outputs are registered or derived directly from registers. There are no combinational paths from in_valid to in_ready or tx.

Decomposition:
- Package sum_uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP), 2 bits;
  - DATA_W=8, FRAME_BITS=10, and UART_IDLE=1'b1.
- Sub-module sync_fifo (WIDTH, DEPTH): push/pop, full, empty, level, asynchronous active-low reset. Instantiated once.
- The FSM, baud counter and shift register live in sum_uart_tx.

Test Plan:
1. Reset: hold rst_n=0 for 5 cycles mid-stream -> tx=1, busy=0, in_ready=0, fifo_level=0 immediately; in_ready=1 one edge after release.
2. Single byte, CLKS_PER_BIT=4: push 0xA5 -> tx low from edge 2 for 4 cycles. Data bits are 1,0,1,0,0,1,0,1, 4 cycles each, then stop high for 4 cycles. busy drops at cycle 42.
3. Back-to-back: push 0x00, 0xFF, 0x3C on consecutive cycles -> three contiguous 40-cycle frames with no idle cycles between stop and start. fifo_level sequence is 1,1,2 (the first byte is popped on push of the second).
4. Full FIFO (DEPTH=4): hold in_valid=1 for 8 cycles with a frame in progress -> in_ready=0 once level=4. Only 5 bytes are accepted (1 in shift register + 4 buffered). Transmitted order matches push order.
5. Simultaneous push/pop: at the end of a stop bit, push while level=2 -> level stays 2 and the next frame starts without a gap.
6. Reset mid-DATA: assert rst_n=0 during bit 3 of 0x81 -> tx=1 asynchronously. After release, no residual frame is emitted and fifo_level=0.
